// File: rtl/vram_pkg.sv
// Shared VRAM constants and the write-request payload type.
package vram_pkg;

  localparam int VRAM_AW = 13;

  // Display fetch owns phases 15, 0, 1, 2; everything in this range is free for CPU writes.
  localparam logic [3:0] PHASE_OPEN_FIRST = 4'd3;
  localparam logic [3:0] PHASE_OPEN_LAST  = 4'd14;

  typedef struct packed {
    logic [VRAM_AW-1:0] addr;
    logic [7:0]         data;
  } vram_wr_t;

endpackage

// File: rtl/vram_wr_fifo.sv
// Small synchronous FIFO; occupancy counter resolves full/empty, pointers wrap modulo DEPTH.
module vram_wr_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 21
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             push_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level,
  output logic [W-1:0]             head
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  // Storage needs no reset: the level counter decides what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/vram_write_port.sv
// CPU write port for the display VRAM: queues byte writes and drains them only in pixel phases free of display fetches.
module vram_write_port
  import vram_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = VRAM_AW
) (
  input  logic                   pixel_clock,
  input  logic                   reset,
  input  logic                   ag,
  input  logic                   show_border,
  input  logic [3:0]             subchar_pixel,
  input  logic [8:0]             graph_pixel,
  input  logic                   cpu_wr_valid,
  input  logic [AW-1:0]          cpu_wr_addr,
  input  logic [7:0]             cpu_wr_data,
  output logic                   cpu_wr_ready,
  output logic                   vram_we,
  output logic [AW-1:0]          vram_waddr,
  output logic [7:0]             vram_wdata,
  output logic [$clog2(DEPTH):0] fifo_level
);

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [7:0]    data;
  } wr_t;

  wr_t        in_wr;
  wr_t        head_wr;
  logic [3:0] phase;
  logic       open;
  logic       full;
  logic       empty;
  logic       issue;
  // Upper column bits are irrelevant to the phase decode.
  logic       unused_col;

  assign unused_col = ^graph_pixel[8:4];
  assign phase      = ag ? graph_pixel[3:0] : subchar_pixel;
  assign open       = show_border | ((phase >= PHASE_OPEN_FIRST) && (phase <= PHASE_OPEN_LAST));
  assign issue      = open & ~empty;
  assign in_wr      = '{addr: cpu_wr_addr, data: cpu_wr_data};
  assign cpu_wr_ready = ~full;

  vram_wr_fifo #(
    .DEPTH (DEPTH),
    .W     ($bits(wr_t))
  ) u_fifo (
    .clk       (pixel_clock),
    .reset     (reset),
    .push      (cpu_wr_valid),
    .pop       (issue),
    .push_data (in_wr),
    .full      (full),
    .empty     (empty),
    .level     (fifo_level),
    .head      (head_wr)
  );

  always_ff @(posedge pixel_clock) begin
    if (reset) begin
      vram_we    <= 1'b0;
      vram_waddr <= '0;
      vram_wdata <= '0;
    end else if (issue) begin
      vram_we    <= 1'b1;
      vram_waddr <= head_wr.addr;
      vram_wdata <= head_wr.data;
    end else begin
      vram_we    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vram_write_port.sv
// Bench for vram_write_port: queue-based reference model plus directed scenarios.
module tb_vram_write_port;
  import vram_pkg::*;

  localparam int DEPTH = 4;

  logic        pixel_clock = 1'b0;
  logic        reset;
  logic        ag;
  logic        show_border;
  logic [3:0]  subchar_pixel;
  logic [8:0]  graph_pixel;
  logic        cpu_wr_valid;
  logic [12:0] cpu_wr_addr;
  logic [7:0]  cpu_wr_data;
  logic        cpu_wr_ready;
  logic        vram_we;
  logic [12:0] vram_waddr;
  logic [7:0]  vram_wdata;
  logic [2:0]  fifo_level;

  vram_write_port #(.DEPTH(DEPTH), .AW(13)) dut (
    .pixel_clock   (pixel_clock),
    .reset         (reset),
    .ag            (ag),
    .show_border   (show_border),
    .subchar_pixel (subchar_pixel),
    .graph_pixel   (graph_pixel),
    .cpu_wr_valid  (cpu_wr_valid),
    .cpu_wr_addr   (cpu_wr_addr),
    .cpu_wr_data   (cpu_wr_data),
    .cpu_wr_ready  (cpu_wr_ready),
    .vram_we       (vram_we),
    .vram_waddr    (vram_waddr),
    .vram_wdata    (vram_wdata),
    .fifo_level    (fifo_level)
  );

  always #5 pixel_clock = ~pixel_clock;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: mq is the scoreboard of accepted writes awaiting issue.
  vram_wr_t    mq[$];
  vram_wr_t    m_item;
  logic        m_we = 1'b0;
  logic [3:0]  last_phase = '0;
  logic        last_border = 1'b0;
  logic [3:0]  ph;
  logic        op;
  logic        do_pop;
  logic        do_push;

  always @(posedge pixel_clock) begin
    if (reset) begin
      mq.delete();
      m_we = 1'b0;
    end else begin
      ph      = ag ? graph_pixel[3:0] : subchar_pixel;
      op      = show_border || (ph >= 4'd3 && ph <= 4'd14);
      do_pop  = op && (mq.size() != 0);
      do_push = cpu_wr_valid && (mq.size() != DEPTH);
      m_we    = do_pop;
      if (do_pop) m_item = mq.pop_front();
      if (do_push) mq.push_back('{addr: cpu_wr_addr, data: cpu_wr_data});
      last_phase  = ph;
      last_border = show_border;
    end
  end

  logic        chk_en = 1'b0;
  int          pulses = 0;
  logic [12:0] seen[$];

  always @(negedge pixel_clock) begin
    if (chk_en) begin
      check("we", vram_we, m_we);
      check("level", fifo_level, mq.size());
      check("ready", cpu_wr_ready, mq.size() != DEPTH);
      if (m_we) begin
        check("waddr", vram_waddr, m_item.addr);
        check("wdata", vram_wdata, m_item.data);
      end
      if (vram_we === 1'b1) begin
        pulses++;
        seen.push_back(vram_waddr);
        if (!last_border) check("win_phase", (last_phase >= 4'd3 && last_phase <= 4'd14), 1);
      end
    end
  end

  task automatic step();
    @(negedge pixel_clock);
    #1;
  endtask

  int base;
  int sbase;
  int issue_p;
  int pushed;

  initial begin
    reset = 1'b1; ag = 1'b0; show_border = 1'b0; subchar_pixel = 4'd4; graph_pixel = '0;
    cpu_wr_valid = 1'b1; cpu_wr_addr = 13'h1FFF; cpu_wr_data = 8'hFF;
    step(); step();
    cpu_wr_valid = 1'b0;
    chk_en = 1'b1;
    check("rst_we", vram_we, 0);
    check("rst_waddr", vram_waddr, 0);
    check("rst_wdata", vram_wdata, 0);
    check("rst_level", fifo_level, 0);
    check("rst_ready", cpu_wr_ready, 1);
    reset = 1'b0;
    subchar_pixel = 4'd0;
    step();
    check("rst_nothing_stored", fifo_level, 0);

    // Text mode single write, phase sweep 0..8
    base = pulses; issue_p = -1;
    subchar_pixel = 4'd0; cpu_wr_valid = 1'b1; cpu_wr_addr = 13'h0123; cpu_wr_data = 8'hA5;
    step();
    cpu_wr_valid = 1'b0;
    for (int p = 1; p <= 8; p++) begin
      subchar_pixel = 4'(p);
      step();
      if (vram_we === 1'b1) begin
        issue_p = p;
        check("text_addr", vram_waddr, 13'h0123);
        check("text_data", vram_wdata, 8'hA5);
      end
    end
    check("text_pulses", pulses - base, 1);
    check("text_issue_phase", issue_p, 3);

    // Backpressure and ordering with the window closed
    subchar_pixel = 4'd0; show_border = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cpu_wr_valid = 1'b1; cpu_wr_addr = 13'(16 + i); cpu_wr_data = 8'(8'h60 + i);
      step();
    end
    cpu_wr_valid = 1'b0;
    check("bp_level", fifo_level, 4);
    check("bp_ready", cpu_wr_ready, 0);
    base = pulses; sbase = seen.size();
    show_border = 1'b1;
    step();
    check("bp_first_we", vram_we, 1);
    check("bp_first_addr", vram_waddr, 13'h010);
    check("bp_ready_back", cpu_wr_ready, 1);
    step(); step(); step();
    show_border = 1'b0;
    step();
    check("bp_drained_we", vram_we, 0);
    check("bp_pulses", pulses - base, 4);
    for (int i = 0; i < 4; i++) begin
      if (seen.size() > sbase + i) check("bp_order", seen[sbase + i], 16 + i);
      else check("bp_order_missing", seen.size(), sbase + 4);
    end

    // Border overrides a closed phase
    show_border = 1'b1; subchar_pixel = 4'd1;
    cpu_wr_valid = 1'b1; cpu_wr_addr = 13'h0777; cpu_wr_data = 8'h3C;
    step();
    cpu_wr_valid = 1'b0;
    check("border_no_bypass", vram_we, 0);
    step();
    check("border_we", vram_we, 1);
    check("border_addr", vram_waddr, 13'h0777);
    check("border_data", vram_wdata, 8'h3C);
    show_border = 1'b0; subchar_pixel = 4'd0;
    step();

    // Graphics mode, free-running column, 8 writes
    ag = 1'b1; graph_pixel = 9'h1F8; pushed = 0; base = pulses;
    for (int c = 0; c < 100; c++) begin
      graph_pixel = graph_pixel + 9'd1;
      if (pushed < 8 && mq.size() < DEPTH) begin
        cpu_wr_valid = 1'b1; cpu_wr_addr = 13'(13'h1A00 + pushed); cpu_wr_data = 8'(pushed * 17);
        pushed++;
      end else begin
        cpu_wr_valid = 1'b0;
      end
      step();
    end
    cpu_wr_valid = 1'b0;
    check("gfx_pulses", pulses - base, 8);
    check("gfx_level", fifo_level, 0);

    // Reset in the middle of a drain
    ag = 1'b0; subchar_pixel = 4'd0; show_border = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cpu_wr_valid = 1'b1; cpu_wr_addr = 13'(13'h40 + i); cpu_wr_data = 8'(i);
      step();
    end
    cpu_wr_valid = 1'b0;
    check("mid_level", fifo_level, 3);
    subchar_pixel = 4'd5; reset = 1'b1;
    step();
    check("mid_rst_we", vram_we, 0);
    check("mid_rst_level", fifo_level, 0);
    reset = 1'b0; base = pulses;
    for (int i = 0; i < 5; i++) step();
    check("mid_no_pulses", pulses - base, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
